// File: rtl/aui_lane_deskew.sv
// Multi-lane deskew: buffers every lane, finds each lane's alignment marker, releases all lanes
// in lockstep so markers emerge together, and drops lock after persistent marker misalignment.
module aui_lane_deskew #(
  parameter int unsigned NUMBER_LANES = 16,
  parameter int unsigned LANE_WIDTH   = 1360,
  parameter int unsigned MAX_SKEW     = 4,
  parameter int unsigned LOSS_COUNT   = 3,
  localparam int unsigned DEPTH       = MAX_SKEW + 2,
  localparam int unsigned SKEW_W      = $clog2(MAX_SKEW + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  input  logic [NUMBER_LANES*LANE_WIDTH-1:0] i_lanes,
  input  logic [NUMBER_LANES-1:0]            i_sync,
  output logic                               o_valid,
  output logic [NUMBER_LANES*LANE_WIDTH-1:0] o_lanes,
  output logic [NUMBER_LANES-1:0]            o_sync,
  output logic                               o_locked,
  output logic [NUMBER_LANES*SKEW_W-1:0]     o_lane_skew,
  output logic [7:0]                         o_skew_err_cnt
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LOSS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [PTR_W-1:0]  PtrLast   = PTR_W'(DEPTH - 1);
  localparam logic [SKEW_W:0]   CntLimit  = (SKEW_W + 1)'(MAX_SKEW + 1);
  localparam logic [LOSS_W-1:0] LossLimit = LOSS_W'(LOSS_COUNT);

  typedef enum logic [1:0] {StSearch, StCollect, StLocked} state_e;

  state_e                                     state_q, state_d;
  logic [PTR_W-1:0]                           wp_q, wp_d;
  logic [NUMBER_LANES-1:0][PTR_W-1:0]         rp_q, rp_d;
  logic [NUMBER_LANES-1:0]                    seen_q, seen_d;
  logic [SKEW_W-1:0]                          cnt_q, cnt_d;
  logic [SKEW_W:0]                            cnt_inc;
  logic [NUMBER_LANES-1:0][SKEW_W-1:0]        skew_q, skew_d;
  logic [LOSS_W-1:0]                          loss_q, loss_d;
  logic [7:0]                                 err_q, err_d;
  logic                                       o_valid_q, o_valid_d;
  logic [NUMBER_LANES-1:0][LANE_WIDTH-1:0]    o_lanes_q, o_lanes_d;
  logic [NUMBER_LANES-1:0]                    o_sync_q, o_sync_d;
  logic [NUMBER_LANES-1:0][SKEW_W-1:0]        o_lane_skew_q, o_lane_skew_d;
  logic                                       lock_now, fail_now, drop_now;

  // Each entry holds {sync, word}; not reset, since pointers alone define what is live.
  logic [LANE_WIDTH:0] mem_q [NUMBER_LANES][DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_valid) begin
      for (int n = 0; n < NUMBER_LANES; n++) begin
        mem_q[n][wp_q] <= {i_sync[n], i_lanes[n*LANE_WIDTH +: LANE_WIDTH]};
      end
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign wp_d    = i_valid ? ptr_inc(wp_q) : wp_q;

  always_comb begin
    state_d       = state_q;
    rp_d          = rp_q;
    seen_d        = seen_q;
    cnt_d         = cnt_q;
    skew_d        = skew_q;
    loss_d        = loss_q;
    err_d         = err_q;
    o_valid_d     = 1'b0;
    o_lanes_d     = o_lanes_q;
    o_sync_d      = o_sync_q;
    o_lane_skew_d = o_lane_skew_q;
    lock_now      = 1'b0;
    fail_now      = 1'b0;
    drop_now      = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (i_valid && |i_sync) begin
          seen_d = i_sync;
          cnt_d  = '0;
          for (int n = 0; n < NUMBER_LANES; n++) begin
            if (i_sync[n]) begin
              rp_d[n]   = wp_q;
              skew_d[n] = '0;
            end
          end
          if (&i_sync) lock_now = 1'b1;
          else         state_d  = StCollect;
        end
      end
      StCollect: begin
        if (i_valid) begin
          cnt_d  = cnt_inc[SKEW_W-1:0];
          seen_d = seen_q | i_sync;
          for (int n = 0; n < NUMBER_LANES; n++) begin
            if (i_sync[n] && !seen_q[n]) begin
              rp_d[n]   = wp_q;
              skew_d[n] = cnt_inc[SKEW_W-1:0];
            end
          end
          // Window expiry wins even if the late lane would complete the mask this cycle.
          if (|(i_sync & seen_q) || cnt_inc == CntLimit) fail_now = 1'b1;
          else if (&seen_d)                               lock_now = 1'b1;
        end
      end
      StLocked: begin
        if (o_valid_q) begin
          if (&o_sync_q)      loss_d = '0;
          else if (|o_sync_q) loss_d = loss_q + LOSS_W'(1);
        end
        if (loss_d == LossLimit) begin
          drop_now = 1'b1;
        end else if (i_valid) begin
          o_valid_d = 1'b1;
          for (int n = 0; n < NUMBER_LANES; n++) begin
            o_lanes_d[n] = mem_q[n][rp_q[n]][LANE_WIDTH-1:0];
            o_sync_d[n]  = mem_q[n][rp_q[n]][LANE_WIDTH];
            rp_d[n]      = ptr_inc(rp_q[n]);
          end
        end
      end
      default: state_d = StSearch;
    endcase
    if (fail_now || drop_now) begin
      err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      seen_d  = '0;
      state_d = StSearch;
    end
    if (lock_now) begin
      state_d       = StLocked;
      loss_d        = '0;
      o_lane_skew_d = skew_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSearch;
      wp_q          <= '0;
      rp_q          <= '0;
      seen_q        <= '0;
      cnt_q         <= '0;
      skew_q        <= '0;
      loss_q        <= '0;
      err_q         <= '0;
      o_valid_q     <= 1'b0;
      o_lanes_q     <= '0;
      o_sync_q      <= '0;
      o_lane_skew_q <= '0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      seen_q        <= seen_d;
      cnt_q         <= cnt_d;
      skew_q        <= skew_d;
      loss_q        <= loss_d;
      err_q         <= err_d;
      o_valid_q     <= o_valid_d;
      o_lanes_q     <= o_lanes_d;
      o_sync_q      <= o_sync_d;
      o_lane_skew_q <= o_lane_skew_d;
    end
  end

  assign o_valid        = o_valid_q;
  assign o_lanes        = o_lanes_q;
  assign o_sync         = o_sync_q;
  assign o_locked       = (state_q == StLocked);
  assign o_lane_skew    = o_lane_skew_q;
  assign o_skew_err_cnt = err_q;

endmodule

// File: tb/tb_aui_lane_deskew.sv
// Randomized bench for aui_lane_deskew: a word-history reference model feeds a scoreboard
// that a separate monitor drains whenever the deskewer presents output.
module tb_aui_lane_deskew;
  localparam int NL = 16;
  localparam int LW = 1360;
  localparam int MS = 4;
  localparam int LC = 3;
  localparam int SW = 3;
  localparam int P  = 10;  // marker period in valid words

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid;
  logic [NL*LW-1:0]     i_lanes;
  logic [NL-1:0]        i_sync;
  logic                 o_valid;
  logic [NL*LW-1:0]     o_lanes;
  logic [NL-1:0]        o_sync;
  logic                 o_locked;
  logic [NL*SW-1:0]     o_lane_skew;
  logic [7:0]           o_skew_err_cnt;

  aui_lane_deskew #(
    .NUMBER_LANES(NL), .LANE_WIDTH(LW), .MAX_SKEW(MS), .LOSS_COUNT(LC)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_lanes(i_lanes), .i_sync(i_sync),
    .o_valid(o_valid), .o_lanes(o_lanes), .o_sync(o_sync), .o_locked(o_locked),
    .o_lane_skew(o_lane_skew), .o_skew_err_cnt(o_skew_err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: 0 = searching, 1 = collecting markers, 2 = locked
  logic [LW-1:0]  hist  [NL][64];
  bit             hsync [NL][64];
  int             m_state, vidx, first_v, k, loss, err;
  int             mk [NL];
  int             skew_exp [NL];
  logic [NL-1:0]  seen;
  bit             last_ov;
  logic [NL-1:0]  last_os;

  bit             pend_rst, pend_valid, pend_locked;
  int             pend_err;
  logic [NL*SW-1:0] pend_skew;
  bit             cur_rst, cur_valid, cur_locked, chk_en = 1'b0;
  int             cur_err;
  logic [NL*SW-1:0] cur_skew;

  logic [NL*LW-1:0] q_lanes [$];
  logic [NL-1:0]    q_sync  [$];

  // Stimulus generator state
  int gen_v = 0;
  int off  [NL];
  int off2 [NL];

  task automatic model_lock();
    m_state = 2;
    k       = 0;
    loss    = 0;
    for (int n = 0; n < NL; n++) skew_exp[n] = mk[n] - first_v;
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [NL*LW-1:0] ln,
                            input logic [NL-1:0] sy);
    bit               out_v = 1'b0;
    bit               dropped = 1'b0;
    logic [NL*LW-1:0] out_l = '0;
    logic [NL-1:0]    out_s = '0;
    if (r) begin
      m_state = 0; seen = '0; loss = 0; err = 0; k = 0; last_ov = 0; last_os = '0;
      for (int n = 0; n < NL; n++) skew_exp[n] = 0;
      pend_rst = 1; pend_valid = 0; pend_locked = 0; pend_err = 0; pend_skew = '0;
      return;
    end
    pend_rst = 0;
    if (m_state == 2 && last_ov) begin
      if (last_os == {NL{1'b1}}) loss = 0;
      else if (last_os != '0)    loss++;
      if (loss == LC) begin
        dropped = 1; loss = 0; m_state = 0; seen = '0;
        if (err < 255) err++;
      end
    end
    if (v) begin
      for (int n = 0; n < NL; n++) begin
        hist[n][vidx % 64]  = ln[n*LW +: LW];
        hsync[n][vidx % 64] = sy[n];
      end
      if (!dropped) begin
        case (m_state)
          0: if (sy != '0) begin
            first_v = vidx;
            seen    = sy;
            for (int n = 0; n < NL; n++) if (sy[n]) mk[n] = vidx;
            if (sy == {NL{1'b1}}) model_lock();
            else                  m_state = 1;
          end
          1: begin
            if ((sy & seen) != '0 || vidx - first_v == MS + 1) begin
              seen = '0; m_state = 0;
              if (err < 255) err++;
            end else begin
              for (int n = 0; n < NL; n++) if (sy[n] && !seen[n]) mk[n] = vidx;
              seen = seen | sy;
              if (seen == {NL{1'b1}}) model_lock();
            end
          end
          default: begin
            out_v = 1;
            for (int n = 0; n < NL; n++) begin
              out_l[n*LW +: LW] = hist[n][(mk[n] + k) % 64];
              out_s[n]          = hsync[n][(mk[n] + k) % 64];
            end
            k++;
          end
        endcase
      end
      vidx++;
    end
    last_ov = out_v;
    if (out_v) begin
      last_os = out_s;
      q_lanes.push_back(out_l);
      q_sync.push_back(out_s);
    end
    pend_valid  = out_v;
    pend_locked = (m_state == 2);
    pend_err    = err;
    for (int n = 0; n < NL; n++) pend_skew[n*SW +: SW] = SW'(skew_exp[n]);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_lanes(input logic [NL*LW-1:0] exp);
    bit found = 0;
    n_vec++;
    if (o_lanes !== exp) begin
      n_mis++;
      for (int n = 0; n < NL && !found; n++) begin
        for (int c = 0; c < LW / 16 && !found; c++) begin
          if (o_lanes[n*LW + c*16 +: 16] !== exp[n*LW + c*16 +: 16]) begin
            found = 1;
            $display("FAIL o_lanes lane %0d chunk %0d: got %h expected %h (t=%0t)", n, c,
                     o_lanes[n*LW + c*16 +: 16], exp[n*LW + c*16 +: 16], $time);
          end
        end
      end
    end
  endtask

  // Monitor: per-cycle status checks plus scoreboard pop on every o_valid.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", 64'(o_valid), 64'(cur_valid));
      check("o_locked", 64'(o_locked), 64'(cur_locked));
      check("o_skew_err_cnt", 64'(o_skew_err_cnt), 64'(cur_err));
      check("o_lane_skew", 64'(o_lane_skew), 64'(cur_skew));
      if (cur_rst) begin
        check_lanes('0);
        check("o_sync_reset", 64'(o_sync), 64'(0));
      end
      if (o_valid === 1'b1) begin
        if (q_lanes.size() == 0) begin
          check("unexpected_o_valid", 64'(1), 64'(0));
        end else begin
          check_lanes(q_lanes.pop_front());
          check("o_sync", 64'(o_sync), 64'(q_sync.pop_front()));
        end
      end
    end
  end

  task automatic drive_cycle(input bit r, input bit v, input int inj);
    logic [NL*LW-1:0] ln;
    logic [NL-1:0]    sy;
    @(posedge clk);
    #1;
    cur_rst = pend_rst; cur_valid = pend_valid; cur_locked = pend_locked;
    cur_err = pend_err; cur_skew = pend_skew;
    chk_en  = 1'b1;
    for (int i = 0; i < NL * LW / 32; i++) ln[i*32 +: 32] = $urandom;
    if (v) begin
      for (int n = 0; n < NL; n++) begin
        sy[n] = ((gen_v + 100 * P - off[n]) % P == 0) ||
                (off2[n] >= 0 && (gen_v + 100 * P - off2[n]) % P == 0) ||
                ($urandom_range(999) < inj);
      end
      gen_v++;
    end else begin
      sy = NL'($urandom);  // ignored by the design when not valid
    end
    rst = r; i_valid = v; i_lanes = ln; i_sync = sy;
    model_edge(r, v, ln, sy);
  endtask

  task automatic run_phase(input int len, input int vprob, input bit rst_start,
                           input int rst_at, input int shift_lane, input int shift_at,
                           input int inj);
    if (rst_start) drive_cycle(1'b1, 1'b0, 0);
    for (int c = 0; c < len; c++) begin
      if (c == shift_at && shift_lane >= 0) off[shift_lane] = off[shift_lane] + 1;
      drive_cycle(c == rst_at, $urandom_range(99) < vprob, inj);
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_lanes = '0; i_sync = '0;
    vidx = 0;
    model_edge(1'b1, 1'b0, '0, '0);
    for (int n = 0; n < NL; n++) begin off[n] = 0; off2[n] = -1; end
    drive_cycle(1'b1, 1'b0, 0);
    drive_cycle(1'b1, 1'b0, 0);

    // All lanes aligned
    run_phase(40, 100, 1, -1, -1, -1, 0);
    // Lanes 0-4 at t, lane 5 at t+3, rest at t+1
    for (int n = 0; n < NL; n++) off[n] = (n < 5) ? 0 : (n == 5) ? 3 : 1;
    run_phase(50, 100, 1, -1, -1, -1, 0);
    // Lane 15 five words late: window expires every attempt
    for (int n = 0; n < NL; n++) off[n] = (n == 15) ? 5 : 0;
    run_phase(50, 100, 1, -1, -1, -1, 0);
    // Lane 2 re-syncs before lane 9 arrives
    for (int n = 0; n < NL; n++) off[n] = (n == 9) ? 3 : 0;
    off2[2] = 1;
    run_phase(50, 100, 1, -1, -1, -1, 0);
    off2[2] = -1;
    // Lane 7 slips by one word after lock, then relocks with the new skew
    for (int n = 0; n < NL; n++) off[n] = $urandom_range(3);
    run_phase(100, 100, 1, -1, 7, 40, 0);
    // Valid toggling with a reset in the middle
    for (int n = 0; n < NL; n++) off[n] = $urandom_range(4);
    run_phase(80, 50, 1, 25, -1, -1, 0);

    for (int p = 0; p < 24; p++) begin
      int base = $urandom_range(3);
      for (int n = 0; n < NL; n++) off[n] = base + $urandom_range(4 - base);
      if ($urandom_range(5) == 0) off[$urandom_range(NL - 1)] = base + 5;
      run_phase(90, ($urandom_range(2) == 0) ? 100 : 40 + $urandom_range(55),
                $urandom_range(2) == 0,
                ($urandom_range(3) == 0) ? int'($urandom_range(80)) : -1,
                ($urandom_range(2) == 0) ? int'($urandom_range(NL - 1)) : -1,
                50, ($urandom_range(3) == 0) ? 3 : 0);
    end

    for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(q_lanes.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
